// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value,
// the logical mixing functions and the compression-core state type.
package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/configure_count_k_w.sv
// Round counter, 16-word circular message schedule and K lookup;
// presents Wt and Kt for the round currently being executed.
module configure_count_k_w import sha256_pkg::*; #(
  parameter int IN_W = 512
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            advance,
  input  logic [IN_W-1:0] block_in,
  output logic [31:0]     w_t,
  output logic [31:0]     k_t,
  output logic            last
);

  logic [5:0]  t;
  logic [31:0] w_buf [16];
  logic [3:0]  slot;
  logic [31:0] w_expand;

  // Slot t mod 16 still holds W[t-16]; the other taps sit at fixed offsets.
  assign slot     = t[3:0];
  assign w_expand = small_sigma1(w_buf[slot - 4'd2]) + w_buf[slot - 4'd7]
                  + small_sigma0(w_buf[slot + 4'd1]) + w_buf[slot];
  assign w_t      = (t < 6'd16) ? w_buf[slot] : w_expand;
  assign k_t      = K[t];
  assign last     = (t == 6'd63);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t <= '0;
      for (int i = 0; i < 16; i++) w_buf[i] <= '0;
    end else if (load) begin
      t <= '0;
      for (int i = 0; i < 16; i++) w_buf[i] <= block_in[IN_W-1-32*i -: 32];
    end else if (advance) begin
      t           <= t + 6'd1;
      w_buf[slot] <= w_t;
    end
  end

endmodule

// File: rtl/hash_round.sv
// SHA-256 compression core: one round per clock over a 512-bit block,
// with the final feed-forward into the chaining value.
module hash_round import sha256_pkg::*; #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  block_in,
  input  logic [OUT_W-1:0] hash_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] digest
);

  state_t      state, next_state;
  logic        accept, advance, finish, last;
  logic [31:0] w_t, k_t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] hs [8];
  logic [31:0] t1, t2, a_next, e_next;

  configure_count_k_w #(.IN_W(IN_W)) u_sched (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .advance  (advance),
    .block_in (block_in),
    .w_t      (w_t),
    .k_t      (k_t),
    .last     (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        advance = 1'b1;
        if (last) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign t1     = h + big_sigma1(e) + ch(e, f, g) + k_t + w_t;
  assign t2     = big_sigma0(a) + maj(a, b, c);
  assign a_next = t1 + t2;
  assign e_next = d + t1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 8; i++) hs[i] <= '0;
    end else if (accept) begin
      {a, b, c, d, e, f, g, h} <= hash_in;
      for (int i = 0; i < 8; i++) hs[i] <= hash_in[OUT_W-1-32*i -: 32];
    end else if (advance) begin
      {a, b, c, d, e, f, g, h} <= {a_next, a, b, c, e_next, e, f, g};
    end
  end

  // The feed-forward uses this cycle's round result so digest lands at E64.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      digest <= '0;
    end else begin
      done <= finish;
      if (finish) begin
        digest <= {hs[0] + a_next, hs[1] + a, hs[2] + b, hs[3] + c,
                   hs[4] + e_next, hs[5] + e, hs[6] + f, hs[7] + g};
      end
    end
  end

endmodule

// File: tb/tb_hash_round.sv
// Self-checking bench for hash_round: known-answer vectors plus random
// blocks compared against a plain-arithmetic SHA-256 compression model.
module tb_hash_round;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] IV_WORDS = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  hash_round #(.IN_W(512), .OUT_W(256)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .busy     (busy),
    .done     (done),
    .digest   (digest)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] model_compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[i] + w[i];
      s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] random_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] random_hash();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse start with the given inputs and wait (bounded) for done.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] hv,
                           output int lat, output logic [255:0] dig);
    block_in = blk;
    hash_in  = hv;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    dig = digest;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    block_in = '0;
    hash_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (digest !== '0) begin errors++; $display("[TB] FAIL reset_digest got %h want 0", digest); end
    reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_known(input string name, input logic [511:0] blk, input logic [255:0] want);
    int lat;
    logic [255:0] dig;
    run_block(blk, IV_WORDS, lat, dig);
    checks++; if (lat !== 64) begin errors++; $display("[TB] FAIL %s_latency got %0d want 64", name, lat); end
    checks++; if (dig !== want) begin errors++; $display("[TB] FAIL %s_digest got %h want %h", name, dig, want); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_at_done got %b want 0", name, busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_width got %b want 0", name, done); end
    checks++; if (digest !== want) begin errors++; $display("[TB] FAIL %s_digest_held got %h want %h", name, digest, want); end
  endtask

  task automatic test_two_block();
    string msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    logic [511:0] blk1, blk2;
    logic [255:0] mid, dig;
    int lat;
    blk1 = '0;
    for (int i = 0; i < msg.len(); i++) blk1[511-8*i -: 8] = msg[i];
    blk1[511-8*56 -: 8] = 8'h80;
    blk2 = {448'h0, 64'd448};
    mid = model_compress(IV_WORDS, blk1);
    run_block(blk1, IV_WORDS, lat, dig);
    checks++; if (dig !== mid) begin errors++; $display("[TB] FAIL two_block_first got %h want %h", dig, mid); end
    run_block(blk2, mid, lat, dig);
    checks++; if (dig !== TWO_DIG) begin errors++; $display("[TB] FAIL two_block_final got %h want %h", dig, TWO_DIG); end
  endtask

  task automatic test_random();
    logic [511:0] blk;
    logic [255:0] hv, want, dig;
    int lat;
    for (int n = 0; n < 4; n++) begin
      blk  = random_block();
      hv   = random_hash();
      want = model_compress(hv, blk);
      run_block(blk, hv, lat, dig);
      checks++; if (dig !== want) begin errors++; $display("[TB] FAIL random%0d_digest got %h want %h", n, dig, want); end
      checks++; if (lat !== 64) begin errors++; $display("[TB] FAIL random%0d_latency got %0d want 64", n, lat); end
    end
  endtask

  task automatic test_busy_ignore();
    int done_cnt = 0;
    int done_at = -1;
    bit busy_ok = 1'b1;
    block_in = ABC_BLK;
    hash_in  = IV_WORDS;
    start    = 1'b1;
    step();
    for (int c = 1; c <= 140; c++) begin
      start = (c == 10 || c == 30);
      if (c == 10 || c == 20 || c == 30) begin
        block_in = random_block();
        hash_in  = random_hash();
      end
      step();
      if (c < 64 && busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    checks++; if (!busy_ok) begin errors++; $display("[TB] FAIL ignore_busy_held got 0 want 1"); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d want 1", done_cnt); end
    checks++; if (done_at !== 64) begin errors++; $display("[TB] FAIL ignore_done_cycle got %0d want 64", done_at); end
    checks++; if (digest !== ABC_DIG) begin errors++; $display("[TB] FAIL ignore_digest got %h want %h", digest, ABC_DIG); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [255:0] dig;
    block_in = random_block();
    hash_in  = random_hash();
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", done); end
    checks++; if (digest !== '0) begin errors++; $display("[TB] FAIL abort_digest got %h want 0", digest); end
    #2 reset = 1'b0;
    step();
    run_block(ABC_BLK, IV_WORDS, lat, dig);
    checks++; if (dig !== ABC_DIG) begin errors++; $display("[TB] FAIL post_abort_digest got %h want %h", dig, ABC_DIG); end
    checks++; if (lat !== 64) begin errors++; $display("[TB] FAIL post_abort_latency got %0d want 64", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    logic [255:0] dig, hv2, want;
    logic [511:0] blk2;
    run_block(ABC_BLK, IV_WORDS, lat, dig);
    checks++; if (dig !== ABC_DIG) begin errors++; $display("[TB] FAIL b2b_first got %h want %h", dig, ABC_DIG); end
    blk2 = random_block();
    hv2  = random_hash();
    want = model_compress(hv2, blk2);
    block_in = blk2;
    hash_in  = hv2;
    start    = 1'b1;
    step();
    start = 1'b0;
    gap   = 1;
    while (done !== 1'b1 && gap < 200) begin
      step();
      gap++;
    end
    checks++; if (gap !== 65) begin errors++; $display("[TB] FAIL b2b_spacing got %0d want 65", gap); end
    checks++; if (digest !== want) begin errors++; $display("[TB] FAIL b2b_second got %h want %h", digest, want); end
  endtask

  initial begin
    test_reset();
    test_known("abc", ABC_BLK, ABC_DIG);
    test_known("empty", EMPTY_BLK, EMPTY_DIG);
    test_two_block();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
